// File: rtl/bidir_pkg.sv
// Shared definitions for the bidirectional FIFO direction controller.
//   dir_state_t : direction controller states
//   DIR_WRITE   : a_dir value while port A writes into the FIFO
//   DIR_READ    : a_dir value while port A reads from the FIFO
//   is_turning  : true for every state that is part of a turnaround
package bidir_pkg;

    typedef enum logic [2:0] {
        WRITE   = 3'd0,
        W_DRAIN = 3'd1,
        R_DRAIN = 3'd2,
        HS      = 3'd3,
        GUARD   = 3'd4,
        READ    = 3'd5
    } dir_state_t;

    localparam logic DIR_WRITE = 1'b1;
    localparam logic DIR_READ  = 1'b0;

    function automatic logic is_turning(input dir_state_t s);
        return !((s == WRITE) || (s == READ));
    endfunction

endpackage

// File: rtl/bidir_dir_ctrl_sat_counter.sv
// sat_counter: synchronous up-counter that stops at MAX.
// Ports:
//   i_clk   : clock
//   i_srst  : synchronous active-high reset, count -> 0
//   i_clear : synchronous clear, count -> 0 (after reset in priority)
//   i_inc   : add one unless already at MAX
//   o_count : current count
module sat_counter #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         i_clk,
    input  logic         i_srst,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_V)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/bidir_dir_ctrl.sv
// bidir_dir_ctrl: A-side direction controller for async_bidir_fifo.
// Arbitrates a local TX (write) client and RX (read) client for FIFO port A,
// sequences each direction turnaround (drain, peer handshake, guard) and
// bounds the burst length in each direction so neither side starves.
// Ports:
//   a_clk, a_rst          : clock, synchronous active-high reset
//   tx_valid/tx_data/tx_ready : TX client handshake
//   rx_ready/rx_valid/rx_data : RX client handshake (rx_ready doubles as read request)
//   a_dir, a_winc, a_wdata, a_rinc, a_rdata, a_full, a_empty : FIFO port A
//   peer_req (out), peer_ack, peer_drained (in) : turnaround handshake with B side
//   turning               : high while a turnaround is in progress
module bidir_dir_ctrl #(
    parameter int   DSIZE     = 8,
    parameter int   MAX_BURST = 16,
    parameter int   GUARD     = 4,
    parameter logic RST_DIR   = 1'b1
) (
    input  logic             a_clk,
    input  logic             a_rst,
    input  logic             tx_valid,
    input  logic [DSIZE-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_ready,
    output logic             rx_valid,
    output logic [DSIZE-1:0] rx_data,
    output logic             a_dir,
    output logic             a_winc,
    output logic [DSIZE-1:0] a_wdata,
    output logic             a_rinc,
    input  logic [DSIZE-1:0] a_rdata,
    input  logic             a_full,
    input  logic             a_empty,
    output logic             peer_req,
    input  logic             peer_ack,
    input  logic             peer_drained,
    output logic             turning
);

    import bidir_pkg::*;

    // The GUARD parameter hides the package literal of the same name, so the
    // guard state is referenced through this alias.
    localparam dir_state_t ST_GUARD = bidir_pkg::GUARD;

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = $clog2(GUARD + 1);

    localparam logic [BW-1:0] BURST_MAX_V  = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST_V = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] GUARD_LAST_V = GW'(GUARD - 1);

    localparam dir_state_t RST_STATE = (RST_DIR == DIR_WRITE) ? WRITE : READ;

    dir_state_t      r_state;
    dir_state_t      w_state_next;
    logic            r_dir;
    logic [BW-1:0]   w_burst_cnt;
    logic [GW-1:0]   w_guard_cnt;
    logic            w_tx_ready;
    logic            w_rx_valid;
    logic            w_winc;
    logic            w_rinc;
    logic            w_accept;
    logic            w_burst_hit;
    logic            w_guard_last;
    logic            w_turning;
    logic            w_in_guard;

    // ---------------- datapath gating ----------------
    assign w_tx_ready = ~a_rst & (r_state == WRITE) & ~a_full;
    assign w_rx_valid = ~a_rst & (r_state == READ) & ~a_empty;
    assign w_winc     = tx_valid & w_tx_ready;
    assign w_rinc     = rx_ready & w_rx_valid;
    assign w_accept   = w_winc | w_rinc;

    assign w_turning  = is_turning(r_state);
    assign w_in_guard = (r_state == ST_GUARD);

    // Burst limit is judged after this cycle's accept, so the word that
    // reaches MAX_BURST is the last one of the burst.
    assign w_burst_hit = (w_burst_cnt == BURST_MAX_V) |
                         (w_accept & (w_burst_cnt == BURST_LAST_V));

    assign w_guard_last = w_in_guard & (w_guard_cnt == GUARD_LAST_V);

    // ---------------- counters ----------------
    // Held clear during the whole turnaround so each WRITE/READ starts at 0.
    sat_counter #(.MAX(MAX_BURST), .W(BW)) u_burst_cnt (
        .i_clk   (a_clk),
        .i_srst  (a_rst),
        .i_clear (w_turning),
        .i_inc   (w_accept),
        .o_count (w_burst_cnt)
    );

    sat_counter #(.MAX(GUARD), .W(GW)) u_guard_cnt (
        .i_clk   (a_clk),
        .i_srst  (a_rst),
        .i_clear (~w_in_guard),
        .i_inc   (w_in_guard),
        .o_count (w_guard_cnt)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            r_state <= RST_STATE;
            r_dir   <= RST_DIR;
        end else begin
            r_state <= w_state_next;
            // Toggle at the end of the last guard cycle so the new
            // WRITE/READ state already sees the new direction.
            if (w_guard_last) begin
                r_dir <= ~r_dir;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WRITE: begin
                if (rx_ready && (!tx_valid || w_burst_hit)) begin
                    w_state_next = W_DRAIN;
                end
            end
            W_DRAIN: begin
                if (peer_drained) begin
                    w_state_next = HS;
                end
            end
            R_DRAIN: begin
                // Unread words simply stay in the FIFO for later.
                w_state_next = HS;
            end
            HS: begin
                if (peer_ack) begin
                    w_state_next = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (w_guard_last) begin
                    w_state_next = (r_dir == DIR_WRITE) ? READ : WRITE;
                end
            end
            READ: begin
                if (tx_valid && (!rx_ready || a_empty || w_burst_hit)) begin
                    w_state_next = R_DRAIN;
                end
            end
            default: begin
                w_state_next = RST_STATE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    assign tx_ready = w_tx_ready;
    assign rx_valid = w_rx_valid;
    assign a_winc   = w_winc;
    assign a_rinc   = w_rinc;
    assign a_wdata  = tx_data;
    assign rx_data  = a_rdata;
    assign a_dir    = r_dir;
    assign peer_req = (r_state == HS) | w_in_guard;
    assign turning  = w_turning;

endmodule
